data_mem_responder: RTL

- Data-memory responder at the far end of the pipelined processor's load/store port.
- Accepts one request at a time on a valid/ready handshake and performs a 64-bit little-endian memory access with configurable latency.
- Returns read data or an error on a separate valid/ready response channel.
- Replaces the zero-latency data memory so MEM-stage stall logic and the processor bench can be exercised against a realistic slave.

---
 rtl/mem_if_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the load/store data-memory port: access sizes,
// responder FSM states and the per-size alignment mask.
package mem_if_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input size_e sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for one 64-bit little-endian word:
// load extract/extend, store byte-merge and misalignment detection.
module lsu_lane_align
  import mem_if_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [63:0] rdata_o,
  output logic [63:0] word_o,
  output logic        misaligned_o
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] wshift;
  logic [7:0]  size_bytes;
  logic [7:0]  byte_en;

  assign shamt  = {offset_i, 3'b000};
  assign lane   = word_i >> shamt;
  assign wshift = wdata_i << shamt;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can infer a latch.
  always_comb begin
    rdata_o = '0;
    case (size_i)
      SZ_B:    rdata_o = unsigned_i ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      SZ_H:    rdata_o = unsigned_i ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      SZ_W:    rdata_o = unsigned_i ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: rdata_o = lane;
    endcase
  end

  always_comb begin
    size_bytes = 8'h00;
    case (size_i)
      SZ_B:    size_bytes = 8'h01;
      SZ_H:    size_bytes = 8'h03;
      SZ_W:    size_bytes = 8'h0F;
      default: size_bytes = 8'hFF;
    endcase
  end

  // Lanes shifted past byte 7 drop off; that only happens when misaligned,
  // and misaligned stores never commit.
  assign byte_en = size_bytes << offset_i;

  always_comb begin
    word_o = word_i;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) word_o[8*i +: 8] = wshift[8*i +: 8];
    end
  end

  assign misaligned_o = |(offset_i & align_mask(size_i));

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave for the load/store port: one outstanding request,
// fixed access latency, read data or error returned on a response channel.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wr_q;
  logic [63:0] addr_q;
  size_e       size_q;
  logic        uns_q;
  logic [63:0] wdata_q;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             commit;
  logic [IDX_W-1:0] word_idx;
  logic             out_of_range;
  logic             misaligned;
  logic             access_err;
  logic [63:0]      rd_word;
  logic [63:0]      load_data;
  logic [63:0]      merged_word;

  assign word_idx     = addr_q[IDX_W+2:3];
  assign out_of_range = addr_q[63:3] >= 61'(DEPTH_WORDS);
  assign access_err   = out_of_range | misaligned;
  assign rd_word      = mem_q[word_idx];

  lsu_lane_align u_align (
    .word_i       (rd_word),
    .wdata_i      (wdata_q),
    .offset_i     (addr_q[2:0]),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .rdata_o      (load_data),
    .word_o       (merged_word),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          err_d   = access_err;
          rdata_d = (access_err || wr_q) ? 64'd0 : load_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 64'd0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

  // NOTE: the array sits on the async reset because reset must clear every
  // word; this rules out a RAM macro but matches the zeroed-memory contract.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 64'd0;
    end else if (commit && wr_q && !access_err) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
